keypad_entry_ctrl: RTL and testbench

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

---
 rtl/keypad_entry_ctrl.sv | 160 ++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// Keypad number entry: collects up to MAX_DIGITS decimal digits, converts them to binary on '#'.
// Define KEYPAD_ENTRY_SIGN_EN to make 'A' toggle a sign that the commit applies.
module keypad_entry_ctrl #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  key_coord,
  input  logic        data_ack,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic [31:0] bcd_buf,
  output logic [3:0]  digit_cnt,
  output logic        negative,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ENTRY, CONVERT, VALID} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);
  localparam logic [3:0] K_A = 4'd10, K_C = 4'd12, K_STAR = 4'd14, K_HASH = 4'd15;

  // {ok, index} for an active-low one-hot nibble; index 0 is 4'b0111
  function automatic logic [2:0] onehot_idx(input logic [3:0] n);
    case (n)
      4'b0111: return 3'b100;
      4'b1011: return 3'b101;
      4'b1101: return 3'b110;
      4'b1110: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // 0-9 are digits; 10..13 = A..D, 14 = '*', 15 = '#'
  function automatic logic [3:0] key_map(input logic [3:0] rc);
    case (rc)
      4'h0: return 4'd1;   4'h1: return 4'd2;  4'h2: return 4'd3;   4'h3: return 4'd10;
      4'h4: return 4'd4;   4'h5: return 4'd5;  4'h6: return 4'd6;   4'h7: return 4'd11;
      4'h8: return 4'd7;   4'h9: return 4'd8;  4'hA: return 4'd9;   4'hB: return 4'd12;
      4'hC: return 4'd14;  4'hD: return 4'd0;  4'hE: return 4'd15;  default: return 4'd13;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] bcd_q, bcd_d, acc_q, acc_d, out_q, out_d;
  logic [3:0]  cnt_q, cnt_d, rem_q, rem_d;
  logic        neg_q, neg_d, valid_q, valid_d;

  logic [2:0]  rsel, csel;
  logic        key_vld;
  logic [3:0]  key;
  logic [5:0]  shamt;
  logic [3:0]  conv_digit;

  always_comb begin
    rsel       = onehot_idx(key_coord[7:4]);
    csel       = onehot_idx(key_coord[3:0]);
    key_vld    = rsel[2] & csel[2];
    key        = key_map({rsel[1:0], csel[1:0]});
    // rem_q digits still to convert; the most significant remaining one sits at nibble rem_q-1
    shamt      = {rem_q - 4'd1, 2'b00};
    conv_digit = 4'(bcd_q >> shamt);
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    out_d   = out_q;
    valid_d = valid_q;
    case (state_q)
      IDLE, ENTRY: begin
        if (key_vld) begin
          if (key < 4'd10) begin
            if (cnt_q < MAX_CNT) begin
              bcd_d = {bcd_q[27:0], key};
              cnt_d = cnt_q + 4'd1;
            end
            state_d = ENTRY;
          end else if (key == K_STAR && state_q == ENTRY) begin
            bcd_d = bcd_q >> 4;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = IDLE;
          end else if (key == K_C) begin
            bcd_d   = '0;
            cnt_d   = '0;
            neg_d   = 1'b0;
            state_d = IDLE;
          end else if (key == K_HASH && state_q == ENTRY) begin
            acc_d   = '0;
            rem_d   = cnt_q;
            state_d = CONVERT;
          end
`ifdef KEYPAD_ENTRY_SIGN_EN
          else if (key == K_A) begin
            neg_d = ~neg_q;
          end
`endif
        end
      end
      CONVERT: begin
        if (rem_q != 4'd0) begin
          acc_d = (acc_q << 3) + (acc_q << 1) + 32'(conv_digit);
          rem_d = rem_q - 4'd1;
        end else begin
`ifdef KEYPAD_ENTRY_SIGN_EN
          out_d = neg_q ? -acc_q : acc_q;
`else
          out_d = acc_q;
`endif
          valid_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (data_ack) begin
          valid_d = 1'b0;
          bcd_d   = '0;
          cnt_d   = '0;
          neg_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign data_out   = out_q;
  assign data_valid = valid_q;
  assign bcd_buf    = bcd_q;
  assign digit_cnt  = cnt_q;
  assign negative   = neg_q;
  assign busy       = (state_q == CONVERT) || (state_q == VALID);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: vector table, hand-written corner sequences, random keys vs. a digit-list model.
module tb_keypad_entry_ctrl;
`ifdef KEYPAD_ENTRY_SIGN_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0, data_ack = 1'b0;
  logic [7:0]  key_coord = 8'h00;
  logic [31:0] data_out, bcd_buf;
  logic        data_valid, negative, busy;
  logic [3:0]  digit_cnt;

  keypad_entry_ctrl #(.MAX_DIGITS(8)) dut (
    .clk(clk), .rst(rst), .key_coord(key_coord), .data_ack(data_ack),
    .data_out(data_out), .data_valid(data_valid), .bcd_buf(bcd_buf),
    .digit_cnt(digit_cnt), .negative(negative), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit seen_valid = 1'b0;
  always @(posedge data_valid) seen_valid = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] code(input byte ch);
    logic [127:0] m = "123A456B789C*0#D";
    logic [3:0] r, c;
    for (int p = 0; p < 16; p++)
      if (m[8*(15-p) +: 8] == ch) begin
        r = 4'b1000 >> (p / 4);
        c = 4'b1000 >> (p % 4);
        return {~r, ~c};
      end
    return 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press_raw(input logic [7:0] c);
    key_coord = c; tick(); key_coord = 8'h00;
  endtask

  task automatic press(input byte ch);
    press_raw(code(ch));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic ack();
    data_ack = 1'b1; tick(); data_ack = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!data_valid && lat < 20) begin tick(); lat++; end
  endtask

  typedef struct {
    logic [95:0] keys;
    logic [31:0] bcd;
    logic [3:0]  cnt;
    logic        vld;
    logic [31:0] out;
  } vec_t;
  vec_t vecs[11];

  int q[$];
  bit mneg;

  function automatic logic [31:0] model_bcd();
    logic [31:0] b = 0;
    foreach (q[i]) b = (b << 4) | 32'(q[i]);
    return b;
  endfunction

  function automatic logic [31:0] model_val();
    logic [31:0] v = 0;
    foreach (q[i]) v = v * 10 + 32'(q[i]);
    return mneg ? -v : v;
  endfunction

  initial begin
    int lat;
    byte ch;
    logic [127:0] keyset;
    logic [7:0] inv[4];
    logic [31:0] pre;

    vecs[0]  = '{"123#",        32'h123,      4'd3, 1'b1, 32'd123};
    vecs[1]  = '{"45*6",        32'h46,       4'd2, 1'b0, 32'd0};
    vecs[2]  = '{"45*6#",       32'h46,       4'd2, 1'b1, 32'd46};
    vecs[3]  = '{"123456789#",  32'h12345678, 4'd8, 1'b1, 32'd12345678};
    vecs[4]  = '{"7C#",         32'h0,        4'd0, 1'b0, 32'd0};
    vecs[5]  = '{"*#",          32'h0,        4'd0, 1'b0, 32'd0};
    vecs[6]  = '{"1B2D#",       32'h12,       4'd2, 1'b1, 32'd12};
    vecs[7]  = '{"A7#",         32'h7,        4'd1, 1'b1, SIGN_EN ? 32'hFFFFFFF9 : 32'd7};
    vecs[8]  = '{"9*#",         32'h0,        4'd0, 1'b0, 32'd0};
    vecs[9]  = '{"00#",         32'h0,        4'd2, 1'b1, 32'd0};
    vecs[10] = '{"87654321#",   32'h87654321, 4'd8, 1'b1, 32'd87654321};

    // reset state
    rst = 1'b1; #1;
    check("rst_out", data_out, 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_cnt", 32'(digit_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    tick(); rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_reset();
      for (int b = 11; b >= 0; b--) begin
        ch = vecs[i].keys[8*b +: 8];
        if (ch != 0) press(ch);
      end
      repeat (12) tick();
      check($sformatf("v%0d_bcd", i), bcd_buf, vecs[i].bcd);
      check($sformatf("v%0d_cnt", i), 32'(digit_cnt), 32'(vecs[i].cnt));
      check($sformatf("v%0d_valid", i), 32'(data_valid), 32'(vecs[i].vld));
      check($sformatf("v%0d_out", i), data_out, vecs[i].out);
      if (vecs[i].vld) begin
        ack();
        check($sformatf("v%0d_ack_valid", i), 32'(data_valid), 0);
        check($sformatf("v%0d_ack_cnt", i), 32'(digit_cnt), 0);
        check($sformatf("v%0d_ack_out", i), data_out, vecs[i].out);
      end
    end

    // latency 3 digits, key together with ack ignored
    do_reset();
    press("1"); press("2"); press("3"); press("#");
    check("lat3_busy", 32'(busy), 1);
    wait_valid(lat);
    check("lat3", lat, 4);
    key_coord = code("5"); data_ack = 1'b1; tick(); key_coord = 8'h00; data_ack = 1'b0;
    check("ackkey_cnt", 32'(digit_cnt), 0);
    check("ackkey_bcd", bcd_buf, 0);
    check("ackkey_busy", 32'(busy), 0);

    // latency at full length, key during VALID ignored
    do_reset();
    for (int d = 1; d <= 9; d++) press(8'h30 + 8'(d));
    press("#");
    wait_valid(lat);
    check("lat8", lat, 9);
    check("lat8_out", data_out, 32'd12345678);
    press("5");
    check("valid_key_bcd", bcd_buf, 32'h12345678);
    check("valid_key_valid", 32'(data_valid), 1);
    ack();

    // invalid code and stray ack in ENTRY
    do_reset();
    press("4"); press_raw(8'h33);
    check("inv_bcd", bcd_buf, 32'h4);
    check("inv_cnt", 32'(digit_cnt), 1);
    ack();
    check("stray_ack_cnt", 32'(digit_cnt), 1);

    // asynchronous reset mid-convert
    do_reset();
    for (int d = 1; d <= 8; d++) press(8'h30 + 8'(d));
    seen_valid = 1'b0;
    press("#");
    repeat (3) tick();
    #2 rst = 1'b1; #1;
    check("arst_out", data_out, 0);
    check("arst_bcd", bcd_buf, 0);
    check("arst_cnt", 32'(digit_cnt), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_neg", 32'(negative), 0);
    tick(); rst = 1'b0;
    repeat (15) tick();
    check("arst_never_valid", 32'(seen_valid), 0);
    check("arst_out_after", data_out, 0);

    // random keys against a digit-list model
    do_reset();
    q.delete(); mneg = 1'b0;
    keyset = "0123456789ABCD*#";
    inv = '{8'h33, 8'hFF, 8'h3E, 8'hE0};
    for (int n = 0; n < 400; n++) begin
      int r;
      bit accepted;
      accepted = 1'b0;
      r = $urandom_range(0, 19);
      if (r >= 16) press_raw(inv[r-16]);
      else begin
        ch = keyset[8*(15-r) +: 8];
        press(ch);
        if (r < 10) begin
          if (q.size() < 8) q.push_back(r);
        end else if (ch == "*") begin
          if (q.size() > 0) void'(q.pop_back());
        end else if (ch == "C") begin
          q.delete(); mneg = 1'b0;
        end else if (ch == "A") begin
          if (SIGN_EN) mneg = ~mneg;
        end else if (ch == "#") begin
          accepted = (q.size() > 0);
        end
      end
      if (accepted) begin
        wait_valid(lat);
        check("rnd_lat", lat, q.size() + 1);
        check("rnd_out", data_out, model_val());
        check("rnd_neg", 32'(negative), 32'(mneg));
        pre = bcd_buf;
        press(8'h30 + 8'($urandom_range(0, 9)));
        check("rnd_valid_key", bcd_buf, pre);
        repeat ($urandom_range(0, 3)) tick();
        ack();
        q.delete(); mneg = 1'b0;
        check("rnd_ack_valid", 32'(data_valid), 0);
        check("rnd_ack_cnt", 32'(digit_cnt), 0);
      end else begin
        check("rnd_bcd", bcd_buf, model_bcd());
        check("rnd_cnt", 32'(digit_cnt), q.size());
        check("rnd_neg", 32'(negative), 32'(mneg));
        check("rnd_valid", 32'(data_valid), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
